data_read_ctrl: RTL

- Read-side sequencer for the 256-entry input-sample circular buffer in data_memory.
- Tracks the write pointer and fill level from the write strobe.
- Per convolution frame, converts a stream of delay values k from the coefficient path into circular read addresses x(n-k).
- Drives dataread/read_enable, registers the returned sample and streams it to the MAC with valid/ready handshakes; x(n-k) with n-k < 0 is returned as zero.

---
 rtl/data_read_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/data_read_ctrl.sv
// data_read_ctrl: read-side sequencer for the circular input-sample buffer in
// data_memory. Tracks the write pointer and fill level, turns per-frame delay
// values k into circular read addresses x(n-k), and streams the returned samples
// to the MAC with valid/ready handshakes. Samples older than the buffer's fill
// level read as zero.
// Optional build macro ZERO_SKIP_EN: while data_memory reports a run of zero
// inputs (flag_zero), accepted delays skip the memory read and return zero.
module data_read_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned K_W    = 8
) (
  input  logic              Sclk,
  input  logic              reset,
  input  logic              wr_strobe,
  input  logic              frame_start,
  input  logic              k_valid,
  output logic              k_ready,
  input  logic [K_W-1:0]    k_data,
  input  logic              k_last,
  output logic              read_enable,
  output logic [ADDR_W-1:0] dataread,
  input  logic [DATA_W-1:0] input_data,
  input  logic              flag_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_busy,
  output logic              frame_done
);

  localparam int unsigned FILL_W = ADDR_W + 1;
  localparam int unsigned CMP_W  = (K_W > FILL_W) ? K_W : FILL_W;
  localparam logic [FILL_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_q,       state_d;
  logic [ADDR_W-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [FILL_W-1:0]   fill_q,        fill_d;
  logic [ADDR_W-1:0]   snap_newest_q, snap_newest_d;
  logic [FILL_W-1:0]   snap_fill_q,   snap_fill_d;
  logic [ADDR_W-1:0]   dataread_q,    dataread_d;
  logic                out_valid_q,   out_valid_d;
  logic [DATA_W-1:0]   out_data_q,    out_data_d;
  logic                out_last_q,    out_last_d;
  logic                frame_busy_q,  frame_busy_d;
  logic                frame_done_q,  frame_done_d;

  logic                k_ready_c;
  logic                k_hs;
  logic                k_in_range;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;

`ifndef ZERO_SKIP_EN
  // flag_zero only matters when zero-skipping is built in
  logic unused_flag_zero;
  assign unused_flag_zero = flag_zero;
`endif

  // Write pointer and saturating fill level follow every write, in any state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (wr_strobe) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (fill_q != DEPTH) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Delay handshake, range test against the snapshot and circular read address
  always_comb begin
    k_ready_c = 1'b0;
    if (state_q == ST_RUN) begin
      k_ready_c = ~out_valid_q | out_ready;
    end
    k_hs       = k_valid & k_ready_c;
    k_in_range = CMP_W'(k_data) < CMP_W'(snap_fill_q);
    rd_addr    = snap_newest_q - ADDR_W'(k_data);
`ifdef ZERO_SKIP_EN
    rd_en      = k_hs & k_in_range & ~flag_zero;
`else
    rd_en      = k_hs & k_in_range;
`endif
    // Address lines keep the last issued address when no read happens
    dataread_d = rd_en ? rd_addr : dataread_q;
  end

  // Frame sequencing, snapshot capture and the output sample register
  always_comb begin
    state_d       = state_q;
    snap_newest_d = snap_newest_q;
    snap_fill_d   = snap_fill_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    frame_done_d  = 1'b0;

    // Consumer took the current sample; a same-cycle new k reloads below
    if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
    if (k_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_en ? input_data : '0;
      out_last_d  = k_last;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          // Pre-increment values: a write in this same cycle is not part of the frame
          state_d       = ST_RUN;
          snap_newest_d = wr_ptr_q - ADDR_W'(1);
          snap_fill_d   = fill_q;
        end
      end
      ST_RUN: begin
        if (k_hs & k_last) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (out_valid_q & out_ready & out_last_q) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    frame_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Sclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      snap_newest_q <= '0;
      snap_fill_q   <= '0;
      dataread_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      snap_newest_q <= snap_newest_d;
      snap_fill_q   <= snap_fill_d;
      dataread_q    <= dataread_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      frame_busy_q  <= frame_busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign k_ready     = k_ready_c;
  assign read_enable = rd_en;
  assign dataread    = dataread_d;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign frame_busy  = frame_busy_q;
  assign frame_done  = frame_done_q;

endmodule
